// File: rtl/reg_request_encoder_if.sv
// Request/grant bundle between the register-bank request logic and the bus controller.
// Out_Error is present only when REG_ENCODER_ERROR_EN is defined.
interface reg_request_encoder_if #(
    parameter int P_RegCount = 8
);
    localparam int ADDR_W = $clog2(P_RegCount);

    logic [P_RegCount-1:0] In_Request;
    logic                  In_Enable;
    logic                  In_Done;
    logic [ADDR_W-1:0]     Out_Address;
    logic                  Out_Valid;
    logic [P_RegCount-1:0] Out_Grant;
`ifdef REG_ENCODER_ERROR_EN
    logic                  Out_Error;
`endif

    // The encoder is the slave; the request bank / bus controller side is the master.
    modport slave (
        input  In_Request,
        input  In_Enable,
        input  In_Done,
        output Out_Address,
        output Out_Valid,
`ifdef REG_ENCODER_ERROR_EN
        output Out_Error,
`endif
        output Out_Grant
    );

    modport master (
        output In_Request,
        output In_Enable,
        output In_Done,
        input  Out_Address,
        input  Out_Valid,
`ifdef REG_ENCODER_ERROR_EN
        input  Out_Error,
`endif
        input  Out_Grant
    );
endinterface

// File: rtl/reg_request_encoder.sv
// Round-robin request encoder: one-hot/multi-hot register requests to a held binary grant.
// Optional sticky protocol error flag enabled by defining REG_ENCODER_ERROR_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no grant active; select from live requests when enabled
// S_GRANT | grant frozen until In_Done; requests and enable are ignored
module reg_request_encoder #(
    parameter int P_RegCount = 8
) (
    input  logic In_Clock,
    input  logic In_Reset_n,
    reg_request_encoder_if.slave bus
);
    localparam int ADDR_W = $clog2(P_RegCount);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic [P_RegCount-1:0] grant_q, grant_d;

    logic                  req_any;
    logic                  hi_found;
    logic [ADDR_W-1:0]     hi_idx;
    logic [ADDR_W-1:0]     any_idx;
    logic [ADDR_W-1:0]     sel_idx;
    logic [P_RegCount-1:0] sel_onehot;
    logic [ADDR_W-1:0]     ptr_inc;

    assign req_any = |bus.In_Request;

    // Lowest set bit at or above the pointer, else lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        any_idx  = '0;
        for (int i = P_RegCount - 1; i >= 0; i--) begin
            if (bus.In_Request[i]) begin
                any_idx = ADDR_W'(i);
                if (i >= int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = ADDR_W'(i);
                end
            end
        end
        sel_idx = hi_found ? hi_idx : any_idx;
    end

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < P_RegCount; i++) begin
            sel_onehot[i] = (ADDR_W'(i) == sel_idx);
        end
    end

    assign ptr_inc = (addr_q == ADDR_W'(P_RegCount - 1)) ? '0 : ADDR_W'(addr_q + 1'b1);

    always_ff @(posedge In_Clock or negedge In_Reset_n) begin
        if (!In_Reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.In_Enable && req_any) state_d = S_GRANT;
            S_GRANT: if (bus.In_Done)              state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values; the address is kept after a grant ends, only valid/grant clear.
    always_comb begin
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                grant_d = '0;
                if (bus.In_Enable && req_any) begin
                    valid_d = 1'b1;
                    addr_d  = sel_idx;
                    grant_d = sel_onehot;
                end
            end
            S_GRANT: begin
                if (bus.In_Done) begin
                    valid_d = 1'b0;
                    grant_d = '0;
                    ptr_d   = ptr_inc;
                end
            end
            default: begin
                valid_d = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    assign bus.Out_Address = addr_q;
    assign bus.Out_Valid   = valid_q;
    assign bus.Out_Grant   = grant_q;

`ifdef REG_ENCODER_ERROR_EN
    logic err_q;
    logic err_set;

    assign err_set = ((state_q == S_IDLE) && bus.In_Done) ||
                     ((state_q == S_GRANT) && ~|(bus.In_Request & grant_q));

    always_ff @(posedge In_Clock or negedge In_Reset_n) begin
        if (!In_Reset_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.Out_Error = err_q;
`endif
endmodule

// File: tb/tb_reg_request_encoder.sv
// Directed-vector bench for reg_request_encoder with P_RegCount=8.
// Error-flag checks are compiled in when REG_ENCODER_ERROR_EN is defined.
module tb_reg_request_encoder;
    localparam int P_RegCount = 8;

    logic clk_sys = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n   = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_request_encoder_if #(.P_RegCount(P_RegCount)) bus ();

    reg_request_encoder #(.P_RegCount(P_RegCount)) dut (
        .In_Clock   (clk_sys),
        .In_Reset_n (rst_n),
        .bus        (bus)
    );

    initial forever #5 if (clk_run) clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] a, input logic [7:0] g);
        chk({tag, ".valid"}, 32'(bus.Out_Valid), 32'(v));
        chk({tag, ".addr"},  32'(bus.Out_Address), 32'(a));
        chk({tag, ".grant"}, 32'(bus.Out_Grant), 32'(g));
    endtask

    // Request, expect a grant on the next edge, then complete it and check the bubble.
    task automatic grant_cycle(input string tag, input logic [7:0] req, input logic [2:0] a);
        bus.In_Request = req;
        bus.In_Enable  = 1'b1;
        tick();
        chk_out(tag, 1'b1, a, 8'(1) << a);
        bus.In_Done = 1'b1;
        tick();
        bus.In_Done = 1'b0;
        chk_out({tag, ".bubble"}, 1'b0, a, 8'h00);
    endtask

    initial begin
        bus.In_Request = '0;
        bus.In_Enable  = 1'b0;
        bus.In_Done    = 1'b0;

        // 1: reset held, no clock, request activity must not leak out
        #3;
        chk_out("rst0", 1'b0, 3'd0, 8'h00);
        bus.In_Request = 8'hFF; bus.In_Enable = 1'b1;
        #7;
        chk_out("rst1", 1'b0, 3'd0, 8'h00);
        bus.In_Request = 8'h5A; bus.In_Done = 1'b1;
        #7;
        chk_out("rst2", 1'b0, 3'd0, 8'h00);
`ifdef REG_ENCODER_ERROR_EN
        chk("rst.err", 32'(bus.Out_Error), 32'd0);
`endif
        bus.In_Request = '0; bus.In_Enable = 1'b0; bus.In_Done = 1'b0;
        clk_run = 1'b1;
        #2 rst_n = 1'b1;
        tick();

        // 2: single request, hold five cycles, then done
        bus.In_Enable  = 1'b1;
        bus.In_Request = 8'b0000_0100;
        tick();
        chk_out("t2.grant", 1'b1, 3'd2, 8'b0000_0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("t2.hold", 1'b1, 3'd2, 8'b0000_0100);
        end
        bus.In_Done = 1'b1;
        tick();
        bus.In_Done = 1'b0;
        bus.In_Request = '0;
        chk_out("t2.done", 1'b0, 3'd2, 8'h00);
        tick();

        // 3: two contenders alternate (pointer was 3 after grant 2 -> 7 first)
        grant_cycle("t3.a", 8'b1000_0001, 3'd7);
        grant_cycle("t3.b", 8'b1000_0001, 3'd0);
        grant_cycle("t3.c", 8'b1000_0001, 3'd7);
        grant_cycle("t3.d", 8'b1000_0001, 3'd0);

        // 4: grant 6 sets pointer 7; then wrap to 0; pointer 1 then picks 6
        grant_cycle("t4.g6",   8'b0100_0000, 3'd6);
        grant_cycle("t4.wrap", 8'b0100_0001, 3'd0);
        grant_cycle("t4.ptr1", 8'b0100_0001, 3'd6);

        // 5: enable low blocks grants; dropping inputs mid-grant has no effect
        bus.In_Enable  = 1'b0;
        bus.In_Request = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5.dis.valid", 32'(bus.Out_Valid), 32'd0);
        end
        bus.In_Enable  = 1'b1;
        bus.In_Request = 8'h01;
        tick();
        chk_out("t5.grant", 1'b1, 3'd0, 8'h01);
        bus.In_Enable  = 1'b0;
        bus.In_Request = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("t5.frozen", 1'b1, 3'd0, 8'h01);
        end
        bus.In_Done = 1'b1;
        tick();
        bus.In_Done = 1'b0;
        chk_out("t5.done", 1'b0, 3'd0, 8'h00);

        // 6: async reset mid-grant, pointer returns to 0
        bus.In_Enable  = 1'b1;
        bus.In_Request = 8'b0000_1000;
        tick();
        chk_out("t6.grant3", 1'b1, 3'd3, 8'b0000_1000);
        #2 rst_n = 1'b0;
        #1;
        chk_out("t6.abort", 1'b0, 3'd0, 8'h00);
        bus.In_Request = 8'b0000_0011;
        #2 rst_n = 1'b1;
        tick();
        chk_out("t6.ptr0", 1'b1, 3'd0, 8'h01);
        bus.In_Done = 1'b1;
        tick();
        bus.In_Done = 1'b0;
        grant_cycle("t6.g1", 8'b0000_1010, 3'd1);
`ifdef REG_ENCODER_ERROR_EN
        chk("t6.err.clear", 32'(bus.Out_Error), 32'd0);
`endif

        // Done while idle: ignored by the grant path, flagged when the error logic exists
        bus.In_Request = 8'h00;
        bus.In_Done    = 1'b1;
        tick();
        bus.In_Done    = 1'b0;
        chk_out("idle.done", 1'b0, 3'd1, 8'h00);
`ifdef REG_ENCODER_ERROR_EN
        chk("idle.err.set", 32'(bus.Out_Error), 32'd1);
`endif
        tick();
        // Pointer is 2 after grant 1, so requests {0,1} wrap to 0
        bus.In_Request = 8'b0000_0011;
        tick();
        chk_out("idle.next", 1'b1, 3'd0, 8'h01);
`ifdef REG_ENCODER_ERROR_EN
        chk("idle.err.sticky", 32'(bus.Out_Error), 32'd1);
`endif
        bus.In_Done = 1'b1;
        tick();
        bus.In_Done = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end
endmodule
